// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, exception-handler FSM, EPC capture and redirect pulse.
// Optional target alignment check enabled by defining PC_ALIGN_CHK_EN.
module pc_unit #(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_VEC = 32'h00003000,
  parameter logic [WIDTH-1:0]     EXC_VEC   = 32'h00004180,
  parameter int unsigned          STEP      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exc_req,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] epc,
  output logic             in_handler,
  output logic             redirect
);

  // Handshake-free block: every input is a single-cycle level sampled on the rising edge;
  // requests have no ready/acknowledge and an ignored request is simply dropped.

  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             redirect_q, redirect_d;

`ifdef PC_ALIGN_CHK_EN
  // STEP is a power of two, so STEP-1 masks the low log2(STEP) bits.
  localparam logic [WIDTH-1:0] ALIGN_MASK = STEP_W - 1'b1;
  logic [WIDTH-1:0] chk_target;
  logic             misaligned;

  always_comb begin
    chk_target = jump ? jump_target : br_target;
    misaligned = (jump || br_taken) && ((chk_target & ALIGN_MASK) != '0);
  end
`endif

  assign pc_plus = pc_q + STEP_W;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    redirect_d = 1'b0;
    if (exc_req && (state_q == RUN)) begin
      pc_d       = EXC_VEC;
      epc_d      = exc_pc;
      state_d    = HANDLER;
      redirect_d = 1'b1;
`ifdef PC_ALIGN_CHK_EN
    end else if (misaligned && (state_q == RUN)) begin
      pc_d       = EXC_VEC;
      epc_d      = chk_target;
      state_d    = HANDLER;
      redirect_d = 1'b1;
`endif
    end else if (eret && (state_q == HANDLER)) begin
      pc_d       = epc_q;
      state_d    = RUN;
      redirect_d = 1'b1;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (jump) begin
      pc_d       = jump_target;
      redirect_d = 1'b1;
    end else if (br_taken) begin
      pc_d       = br_target;
      redirect_d = 1'b1;
    end else begin
      pc_d = pc_plus;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_VEC;
      epc_q      <= '0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      redirect_q <= redirect_d;
    end
  end

  assign pc         = pc_q;
  assign epc        = epc_q;
  assign in_handler = (state_q == HANDLER);
  assign redirect   = redirect_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit: one task per scenario with hand-computed expectations.
`timescale 1ns/1ps
module tb_pc_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         stall;
  logic         br_taken;
  logic [W-1:0] br_target;
  logic         jump;
  logic [W-1:0] jump_target;
  logic         exc_req;
  logic [W-1:0] exc_pc;
  logic         eret;
  logic [W-1:0] pc;
  logic [W-1:0] pc_plus;
  logic [W-1:0] epc;
  logic         in_handler;
  logic         redirect;

  int checks   = 0;
  int failures = 0;

  pc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jump        (jump),
    .jump_target (jump_target),
    .exc_req     (exc_req),
    .exc_pc      (exc_pc),
    .eret        (eret),
    .pc          (pc),
    .pc_plus     (pc_plus),
    .epc         (epc),
    .in_handler  (in_handler),
    .redirect    (redirect)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; br_taken = 0; br_target = '0; jump = 0; jump_target = '0;
    exc_req = 0; exc_pc = '0; eret = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 0;
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    tick();
    checks++;
    if (pc !== 32'h3000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h3000); end
    checks++;
    if (epc !== 32'h0) begin failures++; $display("FAIL reset_epc got=%h exp=0", epc); end
    checks++;
    if (in_handler !== 1'b0) begin failures++; $display("FAIL reset_in_handler got=%b exp=0", in_handler); end
    checks++;
    if (redirect !== 1'b0) begin failures++; $display("FAIL reset_redirect got=%b exp=0", redirect); end
    checks++;
    if (pc_plus !== 32'h3004) begin failures++; $display("FAIL reset_pc_plus got=%h exp=%h", pc_plus, 32'h3004); end
    reset = 1;
  endtask

  task automatic test_sequential();
    logic [W-1:0] exp_pc [3];
    exp_pc[0] = 32'h3004; exp_pc[1] = 32'h3008; exp_pc[2] = 32'h300C;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== exp_pc[i]) begin failures++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc, exp_pc[i]); end
      checks++;
      if (redirect !== 1'b0) begin failures++; $display("FAIL seq_redirect[%0d] got=%b exp=0", i, redirect); end
    end
  endtask

  task automatic test_stall_branch();
    apply_reset();
    tick(); tick();
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (pc !== 32'h3008) begin failures++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, pc, 32'h3008); end
    end
    br_taken = 1; br_target = 32'h3100;
    tick();
    checks++;
    if (pc !== 32'h3008) begin failures++; $display("FAIL stall_blocks_br got=%h exp=%h", pc, 32'h3008); end
    checks++;
    if (redirect !== 1'b0) begin failures++; $display("FAIL stall_redirect got=%b exp=0", redirect); end
    stall = 0;
    tick();
    checks++;
    if (pc !== 32'h3100) begin failures++; $display("FAIL br_pc got=%h exp=%h", pc, 32'h3100); end
    checks++;
    if (redirect !== 1'b1) begin failures++; $display("FAIL br_redirect got=%b exp=1", redirect); end
    clear_inputs();
    tick();
    checks++;
    if (pc !== 32'h3104) begin failures++; $display("FAIL post_br_pc got=%h exp=%h", pc, 32'h3104); end
    checks++;
    if (redirect !== 1'b0) begin failures++; $display("FAIL post_br_redirect got=%b exp=0", redirect); end
  endtask

  task automatic test_jump_priority();
    apply_reset();
    jump = 1; jump_target = 32'h3400;
    br_taken = 1; br_target = 32'h3100;
    tick();
    checks++;
    if (pc !== 32'h3400) begin failures++; $display("FAIL jump_over_br got=%h exp=%h", pc, 32'h3400); end
    checks++;
    if (redirect !== 1'b1) begin failures++; $display("FAIL jump_redirect got=%b exp=1", redirect); end
    clear_inputs();
  endtask

  task automatic test_exception();
    apply_reset();
    tick();
    stall = 1; exc_req = 1; exc_pc = 32'h3010;
    tick();
    checks++;
    if (pc !== 32'h4180) begin failures++; $display("FAIL exc_pc_vec got=%h exp=%h", pc, 32'h4180); end
    checks++;
    if (epc !== 32'h3010) begin failures++; $display("FAIL exc_epc got=%h exp=%h", epc, 32'h3010); end
    checks++;
    if (in_handler !== 1'b1) begin failures++; $display("FAIL exc_in_handler got=%b exp=1", in_handler); end
    checks++;
    if (redirect !== 1'b1) begin failures++; $display("FAIL exc_redirect got=%b exp=1", redirect); end
    exc_pc = 32'h3020;
    tick();
    checks++;
    if (epc !== 32'h3010) begin failures++; $display("FAIL nested_epc got=%h exp=%h", epc, 32'h3010); end
    checks++;
    if (pc !== 32'h4180) begin failures++; $display("FAIL nested_pc got=%h exp=%h", pc, 32'h4180); end
    checks++;
    if (redirect !== 1'b0) begin failures++; $display("FAIL nested_redirect got=%b exp=0", redirect); end
    exc_req = 0; stall = 0;
    tick();
    checks++;
    if (pc !== 32'h4184) begin failures++; $display("FAIL handler_seq got=%h exp=%h", pc, 32'h4184); end
    eret = 1;
    tick();
    checks++;
    if (pc !== 32'h3010) begin failures++; $display("FAIL eret_pc got=%h exp=%h", pc, 32'h3010); end
    checks++;
    if (in_handler !== 1'b0) begin failures++; $display("FAIL eret_in_handler got=%b exp=0", in_handler); end
    checks++;
    if (redirect !== 1'b1) begin failures++; $display("FAIL eret_redirect got=%b exp=1", redirect); end
    eret = 0;
    tick();
    checks++;
    if (pc !== 32'h3014) begin failures++; $display("FAIL post_eret_pc got=%h exp=%h", pc, 32'h3014); end
    checks++;
    if (redirect !== 1'b0) begin failures++; $display("FAIL post_eret_redirect got=%b exp=0", redirect); end
  endtask

  task automatic test_eret_in_run();
    apply_reset();
    eret = 1;
    tick();
    checks++;
    if (pc !== 32'h3004) begin failures++; $display("FAIL eret_run_pc got=%h exp=%h", pc, 32'h3004); end
    checks++;
    if (redirect !== 1'b0) begin failures++; $display("FAIL eret_run_redirect got=%b exp=0", redirect); end
    checks++;
    if (in_handler !== 1'b0) begin failures++; $display("FAIL eret_run_in_handler got=%b exp=0", in_handler); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_handler();
    apply_reset();
    exc_req = 1; exc_pc = 32'h3050;
    tick();
    exc_req = 0;
    reset = 0;
    tick();
    checks++;
    if (pc !== 32'h3000) begin failures++; $display("FAIL midrst_pc got=%h exp=%h", pc, 32'h3000); end
    checks++;
    if (epc !== 32'h0) begin failures++; $display("FAIL midrst_epc got=%h exp=0", epc); end
    checks++;
    if (in_handler !== 1'b0) begin failures++; $display("FAIL midrst_in_handler got=%b exp=0", in_handler); end
    checks++;
    if (redirect !== 1'b0) begin failures++; $display("FAIL midrst_redirect got=%b exp=0", redirect); end
    reset = 1;
  endtask

  task automatic test_wrap();
    apply_reset();
    jump = 1; jump_target = 32'hFFFF_FFFC;
    tick();
    jump = 0;
    checks++;
    if (pc_plus !== 32'h0) begin failures++; $display("FAIL wrap_pc_plus got=%h exp=0", pc_plus); end
    tick();
    checks++;
    if (pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", pc); end
    checks++;
    if (redirect !== 1'b0) begin failures++; $display("FAIL wrap_redirect got=%b exp=0", redirect); end
    clear_inputs();
  endtask

  task automatic test_align();
    apply_reset();
    jump = 1; jump_target = 32'h3402;
    tick();
    clear_inputs();
`ifdef PC_ALIGN_CHK_EN
    checks++;
    if (pc !== 32'h4180) begin failures++; $display("FAIL align_pc got=%h exp=%h", pc, 32'h4180); end
    checks++;
    if (epc !== 32'h3402) begin failures++; $display("FAIL align_epc got=%h exp=%h", epc, 32'h3402); end
    checks++;
    if (in_handler !== 1'b1) begin failures++; $display("FAIL align_in_handler got=%b exp=1", in_handler); end
`else
    checks++;
    if (pc !== 32'h3402) begin failures++; $display("FAIL align_pc got=%h exp=%h", pc, 32'h3402); end
    checks++;
    if (epc !== 32'h0) begin failures++; $display("FAIL align_epc got=%h exp=0", epc); end
    checks++;
    if (in_handler !== 1'b0) begin failures++; $display("FAIL align_in_handler got=%b exp=0", in_handler); end
`endif
    checks++;
    if (redirect !== 1'b1) begin failures++; $display("FAIL align_redirect got=%b exp=1", redirect); end
  endtask

  initial begin
    clear_inputs();
    reset = 0;
    test_reset();
    test_sequential();
    test_stall_branch();
    test_jump_priority();
    test_exception();
    test_eret_in_run();
    test_reset_mid_handler();
    test_wrap();
    test_align();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
